// File: rtl/xtea_ctr_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : xtea_ctr_feeder
//  Description : Counter-mode (CTR) wrapper around a pipelined, non-stallable
//                XTEA encryption core. Issues {nonce, ctr} blocks into the
//                core, tracks the fixed core latency with a tag shift
//                register, buffers plaintext and returning keystream in two
//                FIFOs, and emits plaintext XOR keystream on a valid/ready
//                output. A credit pool bounds everything in flight so the
//                keystream FIFO can never overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module xtea_ctr_feeder #(
  parameter int          CORE_LAT     = 34,
  parameter int          DEPTH        = 64,
  // Counter value applied by ctr_load. Zero in normal use; a non-zero value
  // lets a test environment start near the 32-bit wrap point.
  parameter logic [31:0] CTR_LOAD_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nonce_i,
  input  logic        ctr_load,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [63:0] core_in,
  input  logic [63:0] core_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int            c_AW         = $clog2(DEPTH);
  localparam logic [c_AW:0] c_CREDIT_MAX = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE    = (c_AW + 1)'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]         r_nonce;
  logic [31:0]         r_ctr;
  logic [c_AW:0]       r_credits;
  logic [CORE_LAT-1:0] r_tag;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_AW:0]       r_pt_wr;
  logic [c_AW:0]       r_pt_rd;
  logic [c_AW:0]       r_ks_wr;
  logic [c_AW:0]       r_ks_rd;

  logic [63:0]         r_pt_mem [DEPTH];
  logic [63:0]         r_ks_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Handshakes and derived controls
  // --------------------------------------------------------------------------
  logic        w_issue;
  logic        w_pop;
  logic        w_capture;
  logic        w_load;
  logic [63:0] w_pt_head;
  logic [63:0] w_ks_head;

  assign busy      = (r_credits != c_CREDIT_MAX);
  // A load and an issue must never share a cycle, so ctr_load masks in_ready.
  assign in_ready  = (r_credits != '0) && !ctr_load;
  assign w_issue   = in_valid && in_ready;
  assign out_valid = (r_ks_wr != r_ks_rd);
  assign w_pop     = out_valid && out_ready;
  // The oldest tag leaves the shift register exactly when the core presents
  // the matching keystream word.
  assign w_capture = r_tag[CORE_LAT-1];
  // Reloading the counter is only safe once nothing is outstanding.
  assign w_load    = ctr_load && !busy;

  assign core_in   = {r_nonce, r_ctr};

  assign w_pt_head = r_pt_mem[r_pt_rd[c_AW-1:0]];
  assign w_ks_head = r_ks_mem[r_ks_rd[c_AW-1:0]];
  // Gated so the output bus reads zero whenever nothing is presented,
  // including straight after reset when the memories hold stale data.
  assign out_data  = out_valid ? (w_pt_head ^ w_ks_head) : 64'h0;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Nonce and counter: load when idle, advance by one per issued block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nonce <= 32'h0;
      r_ctr   <= 32'h0;
    end else if (w_load) begin
      r_nonce <= nonce_i;
      r_ctr   <= CTR_LOAD_VAL;
    end else if (w_issue) begin
      r_ctr   <= r_ctr + 32'd1;
    end
  end

  // Credit pool: one credit per block from issue until its result is popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credits <= c_CREDIT_MAX;
    end else if (w_issue && !w_pop) begin
      r_credits <= r_credits - c_PTR_ONE;
    end else if (w_pop && !w_issue) begin
      r_credits <= r_credits + c_PTR_ONE;
    end
  end

  // Tag shift register mirroring the core pipeline occupancy.
  generate
    if (CORE_LAT > 1) begin : g_tag_chain
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_tag <= '0;
        end else begin
          r_tag <= {r_tag[CORE_LAT-2:0], w_issue};
        end
      end
    end else begin : g_tag_single
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_tag <= '0;
        end else begin
          r_tag <= w_issue;
        end
      end
    end
  endgenerate

  // Plaintext FIFO pointers: push on issue, pop on output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pt_wr <= '0;
      r_pt_rd <= '0;
    end else begin
      if (w_issue) begin
        r_pt_wr <= r_pt_wr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_pt_rd <= r_pt_rd + c_PTR_ONE;
      end
    end
  end

  // Keystream FIFO pointers: push on tagged capture, pop on output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ks_wr <= '0;
      r_ks_rd <= '0;
    end else begin
      if (w_capture) begin
        r_ks_wr <= r_ks_wr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_ks_rd <= r_ks_rd + c_PTR_ONE;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_pt_mem[r_pt_wr[c_AW-1:0]] <= in_data;
    end
    if (w_capture) begin
      r_ks_mem[r_ks_wr[c_AW-1:0]] <= core_out;
    end
  end

endmodule
`default_nettype wire

// File: doc/xtea_ctr_feeder.md
Name: xtea_ctr_feeder

Overview:
- Upstream/downstream wrapper around the pipelined XTEA encryption core, turning it into a counter-mode (CTR) stream cipher.
- Generates counter blocks {nonce, ctr} and drives them into the core's in_enc, one per accepted data beat.
- Tracks the core's fixed, non-stallable latency with a tag shift register and captures returning keystream into a FIFO.
- XORs the keystream with the buffered plaintext and presents the result on a valid/ready output, with credit-based flow control so no in-flight result is ever lost.

Parameters:
CORE_LAT, 34, cycles from issue cycle t to the cycle core_out holds that block's result; the core's ROUNDS+2.
DEPTH, 64, entries in the plaintext FIFO, the keystream FIFO and the credit pool; must be a power of two and at least CORE_LAT+1 for full throughput.

Ports:
clk  input  1  single clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset.
nonce_i  input  32  nonce, sampled on ctr_load.
ctr_load  input  1  load nonce_i and clear the counter.
in_valid  input  1  plaintext beat valid.
in_ready  output  1  plaintext beat accepted when in_valid && in_ready.
in_data  input  64  plaintext block.
core_in  output  64  counter block, connects to the core's in_enc.
core_out  input  64  keystream, connects to the core's out_enc.
out_valid  output  1  ciphertext valid.
out_ready  input  1  downstream accepts.
out_data  output  64  ciphertext = plaintext XOR keystream.
busy  output  1  one or more blocks issued but not yet consumed.

Behaviour:
- Reset (reset low, asynchronous):
  - nonce_r, ctr, both FIFOs and all tags cleared; credits = DEPTH.
  - Outputs: out_valid=0, in_ready=1, busy=0, core_in=0, out_data=0.
  - Asserting reset mid-operation discards all in-flight and buffered blocks.
  - Keystream that the core emits after reset deasserts is ignored, because no tags are set.
- core_in:
  - Combinational {nonce_r, ctr}, both registered.
  - The core samples it at the end of every cycle; only issue cycles are tagged.
- in_ready = (credits != 0) && !ctr_load.
- Issue occurs in cycle t when in_valid && in_ready:
  - in_data is pushed into the plaintext FIFO.
  - ctr increments by 1 mod 2^32, wrapping 0xFFFFFFFF to 0.
  - credits decrement.
  - A tag enters the CORE_LAT-deep tag shift register.
- Capture:
  - The tag reaches the end of the shift register in cycle t+CORE_LAT.
  - In that cycle core_out is written into the keystream FIFO.
  - Earliest out_valid is cycle t+CORE_LAT+1.
- Output:
  - out_valid = keystream FIFO not empty.
  - out_data = plaintext FIFO head XOR keystream FIFO head.
  - On out_valid && out_ready, both FIFOs pop and credits increment.
- Ordering: results emerge strictly in issue order. Back-to-back issue (one per cycle) is supported indefinitely while credits remain.
- Credits: bound the plaintext count, in-flight tags and the keystream count to DEPTH combined, so the keystream FIFO never overflows.
- Issue and pop in the same cycle leave credits unchanged.
- Credits reaching 0 drops in_ready in the following cycle. Capture continues while in_ready is low.
- Output stall (out_ready=0): issue continues until credits reach 0. Keystream is still captured because the core cannot stall.
- busy = (credits != DEPTH).
- ctr_load:
  - With busy=0: nonce_r <= nonce_i and ctr <= 0 at the clock edge.
  - With busy=1: ignored, no state change.
  - While ctr_load is high, in_ready is low, so no issue coincides with a load.
- Widths: all arithmetic is 32-bit modulo. credits is log2(DEPTH)+1 bits.

Test Plan:
- Reset then ctr_load with nonce_i=0x12345678, then 1 beat with in_data=0.
  - core_in=0x12345678_00000000 in the issue cycle.
  - out_valid rises exactly 35 cycles later.
  - out_data equals the golden XTEA of that block.
  - busy drops after the pop.
- 100 consecutive beats with random data, out_ready=1.
  - Issue continues every cycle with no in_ready gaps.
  - Outputs are in order; out_data[i] = in_data[i] XOR E(nonce, i).
- out_ready=0 with in_valid held high.
  - Exactly 64 beats accepted, then in_ready=0.
  - 64 results buffered; releasing out_ready drains them in order with none lost.
- Counter wrap: preload ctr to 0xFFFFFFFE via a DUT hook (or 2^32-2 beats in a formal or fast model), then 3 beats.
  - Blocks use ctr 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- ctr_load while busy=1: nonce_r and ctr are unchanged.
- ctr_load asserted together with in_valid: no issue that cycle and the load applies.
- Reset asserted at cycle 10 of a 20-beat burst.
  - Immediately out_valid=0, in_ready=1, busy=0.
  - No spurious output from keystream the core emits afterwards.
